// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter.
// Holds the register address/data widths, the zero-register constant and the
// buffered write entry layout {live, addr, data}.
package wb_arbiter_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_buf.sv
// Circular buffer of deferred long-latency register writes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push, push_addr/data     append a live entry at the tail
//   pop                      retire the head entry
//   head                     head entry (valid when !empty)
//   empty, full              occupancy flags
//   cancel, cancel_addr      clear the live bit of every entry matching cancel_addr
//   look_addr1/2, look_hit1/2  live-entry address match (never hits register 0)
module wb_buf
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WB_ADDR_W-1:0] push_addr,
  input  logic [WB_DATA_W-1:0] push_data,
  input  logic                 pop,
  output wb_entry_t            head,
  output logic                 empty,
  output logic                 full,
  input  logic                 cancel,
  input  logic [WB_ADDR_W-1:0] cancel_addr,
  input  logic [WB_ADDR_W-1:0] look_addr1,
  output logic                 look_hit1,
  input  logic [WB_ADDR_W-1:0] look_addr2,
  output logic                 look_hit2
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[head_ptr];

  // Pointer, count and live-bit state. The push is applied after the cancel
  // so an entry written this cycle is never cancelled by a same-cycle pipe write.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i].live <= 1'b0;
      end
    end else begin
      if (cancel) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (mem[i].addr == cancel_addr) begin
            mem[i].live <= 1'b0;
          end
        end
      end
      if (pop) begin
        mem[head_ptr].live <= 1'b0;
        head_ptr           <= head_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[tail_ptr] <= '{live: 1'b1, addr: push_addr, data: push_data};
        tail_ptr      <= tail_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Pending-write lookups; free slots always have live=0.
  always_comb begin
    look_hit1 = 1'b0;
    look_hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem[i].live && (mem[i].addr == look_addr1)) look_hit1 = 1'b1;
      if (mem[i].live && (mem[i].addr == look_addr2)) look_hit2 = 1'b1;
    end
    if (look_addr1 == ZERO_REG) look_hit1 = 1'b0;
    if (look_addr2 == ZERO_REG) look_hit2 = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file write port.
// Merges the never-stalling MEM/WB write with buffered long-latency results.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pipe_we/waddr/wdata            MEM/WB write (always wins)
//   lu_valid/lu_ready/waddr/wdata  long-latency result handshake
//   we/waddr/wdata                 registered register-file write
//   pend_raddr1/2, pend_hit1/2     ID-stage pending-write lookups (combinational)
// Optional build macro: WB_BYPASS_EN -- an accepted result goes straight to the
// output registers when the buffer is empty and the pipe is idle.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] pend_raddr1,
  output logic              pend_hit1,
  input  logic [ADDR_W-1:0] pend_raddr2,
  output logic              pend_hit2
);

  logic      pipe_real;
  logic      lu_nonzero;
  logic      xfer;
  logic      bypass;
  logic      push;
  logic      pop;
  logic      buf_empty;
  logic      buf_full;
  logic      hit1_raw;
  logic      hit2_raw;
  wb_entry_t head;

  assign pipe_real  = pipe_we && (pipe_waddr != ZERO_REG);
  assign lu_nonzero = (lu_waddr != ZERO_REG);
  assign lu_ready   = !rst && !buf_full;
  assign xfer       = lu_valid && lu_ready;

`ifdef WB_BYPASS_EN
  assign bypass = xfer && lu_nonzero && buf_empty && !pipe_real;
`else
  assign bypass = 1'b0;
`endif

  // Writes to register 0 are accepted but dropped.
  assign push = xfer && lu_nonzero && !bypass;
  assign pop  = !pipe_real && !buf_empty;

  assign pend_hit1 = hit1_raw && !rst;
  assign pend_hit2 = hit2_raw && !rst;

  wb_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (lu_waddr),
    .push_data   (lu_wdata),
    .pop         (pop),
    .head        (head),
    .empty       (buf_empty),
    .full        (buf_full),
    .cancel      (pipe_real),
    .cancel_addr (pipe_waddr),
    .look_addr1  (pend_raddr1),
    .look_hit1   (hit1_raw),
    .look_addr2  (pend_raddr2),
    .look_hit2   (hit2_raw)
  );

  // Output registers: pipe write, then buffer head, then (optionally) bypass.
  // A cancelled head is retired with we=0 and the address/data are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (pipe_real) begin
      we    <= 1'b1;
      waddr <= pipe_waddr;
      wdata <= pipe_wdata;
    end else if (!buf_empty) begin
      we <= head.live;
      if (head.live) begin
        waddr <= head.addr;
        wdata <= head.data;
      end
    end else if (bypass) begin
      we    <= 1'b1;
      waddr <= lu_waddr;
      wdata <= lu_wdata;
    end else begin
      we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a scoreboard queue holds the register writes
// expected on the write port, in order; a monitor retires them as we pulses.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  pend_raddr1;
  logic        pend_hit1;
  logic [4:0]  pend_raddr2;
  logic        pend_hit2;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [36:0] exp_q [$];
  logic [36:0] exp_w;

  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_waddr    (lu_waddr),
    .lu_wdata    (lu_wdata),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .pend_raddr1 (pend_raddr1),
    .pend_hit1   (pend_hit1),
    .pend_raddr2 (pend_raddr2),
    .pend_hit2   (pend_hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    pipe_we    = v;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v;
    lu_waddr = a;
    lu_wdata = d;
  endtask

  // Write-port monitor: every we pulse must match the next queued write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_write: observed waddr=%0d wdata=%0h expected no write", waddr, wdata);
        end
      end else begin
        exp_w = exp_q.pop_front();
        chk("wb_stream", 64'({waddr, wdata}), 64'(exp_w));
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b1, 5'd7, 32'h99);
    pend_raddr1 = 5'd7;
    pend_raddr2 = 5'd0;

    // Reset state
    #1;
    chk("rst_lu_ready", 64'(lu_ready), 64'd0);
    tick();
    tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_pend_hit1", 64'(pend_hit1), 64'd0);
    rst = 1'b0;
    set_lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("post_rst_lu_ready", 64'(lu_ready), 64'd1);
    chk("post_rst_no_pending", 64'(pend_hit1), 64'd0);

    // Single pipe write, one-cycle latency
    set_pipe(1'b1, 5'd3, 32'h11);
    expect_wr(5'd3, 32'h11);
    tick();
    chk("pipe_we", 64'(we), 64'd1);
    chk("pipe_waddr", 64'(waddr), 64'd3);
    chk("pipe_wdata", 64'(wdata), 64'h11);
    chk("pipe_lu_ready", 64'(lu_ready), 64'd1);
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_we", 64'(we), 64'd0);

    // Pipe busy 4 cycles while results r7, r8, r10 arrive; buffer fills
    pend_raddr1 = 5'd7;
    pend_raddr2 = 5'd8;
    for (int i = 0; i < 4; i++) begin
      set_pipe(1'b1, 5'd5, 32'h50 + 32'(i));
      if (i == 0)      set_lu(1'b1, 5'd7, 32'hAA);
      else if (i == 1) set_lu(1'b1, 5'd8, 32'hBB);
      else             set_lu(1'b1, 5'd10, 32'hCC);
      #1;
      chk("fill_lu_ready", 64'(lu_ready), (i < 2) ? 64'd1 : 64'd0);
      expect_wr(5'd5, 32'h50 + 32'(i));
      tick();
      chk("fill_pend_r7", 64'(pend_hit1), 64'd1);
    end
    chk("fill_pend_r8", 64'(pend_hit2), 64'd1);
    set_pipe(1'b0, 5'd0, 32'h0);
    #1;
    chk("full_lu_ready", 64'(lu_ready), 64'd0);
    expect_wr(5'd7, 32'hAA);
    tick();
    chk("drain_r7_we", 64'(we), 64'd1);
    chk("drain_r7_waddr", 64'(waddr), 64'd7);
    chk("drain_r7_pend_gone", 64'(pend_hit1), 64'd0);
    chk("drain_r8_still_pend", 64'(pend_hit2), 64'd1);
    chk("drain_lu_ready", 64'(lu_ready), 64'd1);
    expect_wr(5'd8, 32'hBB);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    chk("drain_r8_we", 64'(we), 64'd1);
    chk("drain_r8_waddr", 64'(waddr), 64'd8);
    chk("drain_r8_pend_gone", 64'(pend_hit2), 64'd0);
    pend_raddr1 = 5'd10;
    #1;
    chk("r10_pend", 64'(pend_hit1), 64'd1);
    expect_wr(5'd10, 32'hCC);
    tick();
    chk("drain_r10_waddr", 64'(waddr), 64'd10);
    chk("r10_pend_gone", 64'(pend_hit1), 64'd0);
    tick();
    chk("drained_we", 64'(we), 64'd0);

    // WAW cancel: buffered r9=1 overtaken by pipe r9=2
    pend_raddr1 = 5'd9;
    set_pipe(1'b1, 5'd5, 32'h60);
    set_lu(1'b1, 5'd9, 32'h1);
    expect_wr(5'd5, 32'h60);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    chk("r9_pend", 64'(pend_hit1), 64'd1);
    set_pipe(1'b1, 5'd9, 32'h2);
    expect_wr(5'd9, 32'h2);
    tick();
    chk("r9_cancel_pend", 64'(pend_hit1), 64'd0);
    chk("r9_pipe_wdata", 64'(wdata), 64'h2);
    set_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk("cancelled_pop_we", 64'(we), 64'd0);
    chk("cancelled_pop_wdata", 64'(wdata), 64'h2);

    // Same-cycle push is newer than the pipe write and survives
    pend_raddr1 = 5'd11;
    set_pipe(1'b1, 5'd11, 32'h3);
    set_lu(1'b1, 5'd11, 32'h4);
    expect_wr(5'd11, 32'h3);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    chk("same_cycle_push_pend", 64'(pend_hit1), 64'd1);
    expect_wr(5'd11, 32'h4);
    tick();
    chk("same_cycle_push_wdata", 64'(wdata), 64'h4);
    chk("same_cycle_pend_gone", 64'(pend_hit1), 64'd0);

    // Register 0 on either source never writes
    pend_raddr1 = 5'd0;
    set_lu(1'b1, 5'd0, 32'hFF);
    #1;
    chk("r0_lu_ready", 64'(lu_ready), 64'd1);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    chk("r0_lu_we", 64'(we), 64'd0);
    chk("r0_pend", 64'(pend_hit1), 64'd0);
    set_pipe(1'b1, 5'd0, 32'h77);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    chk("r0_pipe_we", 64'(we), 64'd0);
    chk("hold_waddr", 64'(waddr), 64'd11);
    chk("hold_wdata", 64'(wdata), 64'h4);
    tick();
    chk("r0_no_push_we", 64'(we), 64'd0);

    // Fill, start draining, then reset mid-drain
    pend_raddr1 = 5'd13;
    set_pipe(1'b1, 5'd5, 32'h70);
    set_lu(1'b1, 5'd12, 32'hC1);
    expect_wr(5'd5, 32'h70);
    tick();
    set_pipe(1'b1, 5'd5, 32'h71);
    set_lu(1'b1, 5'd13, 32'hC2);
    expect_wr(5'd5, 32'h71);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    chk("rst2_full", 64'(lu_ready), 64'd0);
    expect_wr(5'd12, 32'hC1);
    tick();
    chk("rst2_pend_r13", 64'(pend_hit1), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst2_lu_ready", 64'(lu_ready), 64'd0);
    chk("rst2_pend_masked", 64'(pend_hit1), 64'd0);
    tick();
    chk("rst2_we", 64'(we), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst2_after_ready", 64'(lu_ready), 64'd1);
    chk("rst2_after_pend", 64'(pend_hit1), 64'd0);
    tick();
    chk("rst2_no_stale_1", 64'(we), 64'd0);
    tick();
    chk("rst2_no_stale_2", 64'(we), 64'd0);

    // Transfer into an empty buffer with an idle pipe
    pend_raddr1 = 5'd4;
    set_lu(1'b1, 5'd4, 32'h55);
    #1;
    chk("lat_lu_ready", 64'(lu_ready), 64'd1);
    expect_wr(5'd4, 32'h55);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    chk("bypass_we", 64'(we), 64'd1);
    chk("bypass_waddr", 64'(waddr), 64'd4);
    chk("bypass_pend", 64'(pend_hit1), 64'd0);
    tick();
    chk("bypass_pend_after", 64'(pend_hit1), 64'd0);
`else
    chk("lat_we_edge1", 64'(we), 64'd0);
    chk("lat_pend", 64'(pend_hit1), 64'd1);
    tick();
    chk("lat_we_edge2", 64'(we), 64'd1);
    chk("lat_waddr", 64'(waddr), 64'd4);
    chk("lat_wdata", 64'(wdata), 64'h55);
`endif
    tick();
    tick();
    chk("final_we", 64'(we), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
